instr_cache_fill_ctrl: RTL and testbench
========================================

Name: instr_cache_fill_ctrl

Overview:
- Fill responder for the instruction cache: the L2-side end of the replacement interface that the instruction cache set consumes.
- On an L1 miss it latches the block-aligned address, fetches one block from the backing memory as 64-bit beats into a line buffer, then streams the block to the set on rep_active_o/rep_word_o.
- Streaming is exactly B/8 back-to-back cycles, because the set writes one beat per cycle with no stall.
- Sits between the instruction cache and the memory/L2 port.

Parameters:
- B, 64, block size in bytes; multiple of 8, at least 16.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- miss_i  in  1  L1 miss request, level; sampled only in IDLE
- miss_addr_i  in  ADDR_W  faulting fetch byte address
- rep_active_o  out  1  replacement stream active; one beat per cycle
- rep_word_o  out  64  current replacement beat
- fill_done_o  out  1  one-cycle pulse after the last streamed beat
- busy_o  out  1  high in any state other than IDLE
- mem_req_o  out  1  beat read request
- mem_addr_o  out  ADDR_W  beat byte address, 8-byte aligned
- mem_rvalid_i  in  1  read data valid; completes the outstanding request
- mem_rdata_i  in  64  read data

Behaviour:
- Constants: BEATS = B/8; CNT_W = $clog2(BEATS); b = $clog2(B).
- Reset (async assert, sync deassert handled upstream): state IDLE, beat counter 0, base address 0. All outputs 0: rep_active_o, rep_word_o, fill_done_o, busy_o, mem_req_o, mem_addr_o. Line buffer contents are don't-care.
- IDLE:
  - If miss_i=1: latch base = miss_addr_i with bits [b-1:0] cleared, clear the counter, go to FETCH next cycle.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req_o=1 and mem_addr_o = base + 8*cnt, both registered.
  - One request outstanding at a time; mem_req_o stays high until mem_rvalid_i.
  - On mem_rvalid_i: buf[cnt] <= mem_rdata_i.
    - If cnt == BEATS-1: drop mem_req_o, clear the counter, go to STREAM.
    - Otherwise increment cnt; the next address appears the following cycle.
  - Memory stall of any length is legal. mem_rvalid_i outside FETCH is ignored.
- STREAM:
  - rep_active_o=1 for exactly BEATS consecutive cycles; rep_word_o = buf[cnt], registered so the beat and the strobe are aligned.
  - First streamed cycle presents beat 0, matching the set's counter starting at 0.
  - After the cycle with cnt == BEATS-1: go to DONE.
- DONE:
  - One cycle: fill_done_o=1, rep_active_o=0, go to IDLE.
  - miss_i is not sampled in DONE. The set clears its miss once the tag is written on the last beat, so a fresh miss is seen only from IDLE.
- Boundary conditions:
  - miss_i or miss_addr_i changing during FETCH/STREAM/DONE is ignored; the latched fill completes.
  - miss_i held high in IDLE immediately after DONE (different-set miss) starts a new fill.
  - Reset mid-FETCH or mid-STREAM returns to IDLE at once; any partially written block in the set is the set's concern, since its valid bit is already managed there.
  - Address arithmetic is ADDR_W wide; base + 8*cnt never carries past the block because base is aligned.
- Latency (zero-wait memory, rvalid the cycle after req): miss sampled at cycle 0 → mem_req_o at cycle 1 → last beat returned at cycle 2*BEATS → rep_active_o from cycle 2*BEATS+1 for BEATS cycles → fill_done_o at 3*BEATS+1.

Decomposition:
- Package instr_cache_pkg:
  - typedef enum logic [1:0] fill_state_t {FILL_IDLE, FILL_FETCH, FILL_STREAM, FILL_DONE}.
  - localparam BEAT_BYTES = 8.
- One sub-module, fill_line_buffer: BEATS x 64 register array with write port (we, waddr, wdata) and a registered read port (raddr → rdata). Distributed RAM style.
- FSM, counter and address generation stay in the top module.

Test Plan:
- Reset: hold reset_n_i=0 mid-FETCH with mem_req_o=1 → all outputs 0 asynchronously, state IDLE; after release, miss_i=1 starts a clean fill.
- B=64, miss_addr_i=0x0000_1234, zero-wait memory returning data = address → mem_addr_o steps 0x1200, 0x1208 … 0x1238. rep_active_o high 8 consecutive cycles with rep_word_o = 0x1200 … 0x1238 in order. fill_done_o pulses once, one cycle after the last beat.
- Random memory stalls of 0–5 cycles per beat → mem_addr_o held stable while unacknowledged. Stream still 8 contiguous cycles with correct data; no rep_active_o gaps.
- miss_addr_i toggled and miss_i dropped during FETCH → fill completes for the originally latched base; busy_o high throughout.
- miss_i held high through DONE with miss_addr_i=0x2040 → second fill begins from IDLE with base 0x2040; no beat overlap with the first stream.
- Spurious mem_rvalid_i in IDLE and STREAM → no buffer corruption; streamed data unchanged.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared types and constants for the instruction cache fill path.
package instr_cache_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_FETCH,
        FILL_STREAM,
        FILL_DONE
    } fill_state_t;

    localparam int BEAT_BYTES = 8;
    localparam int BEAT_W     = BEAT_BYTES * 8;

endpackage

// File: rtl/instr_cache_fill_ctrl_if.sv
// Bundle of the cache-side replacement stream and the memory-side beat read port.
interface instr_cache_fill_ctrl_if
    import instr_cache_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              miss_i;
    logic [ADDR_W-1:0] miss_addr_i;
    logic              rep_active_o;
    logic [BEAT_W-1:0] rep_word_o;
    logic              fill_done_o;
    logic              busy_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rvalid_i;
    logic [BEAT_W-1:0] mem_rdata_i;

    // The fill controller is the slave of the cache request and drives memory.
    modport slave (
        input  miss_i, miss_addr_i, mem_rvalid_i, mem_rdata_i,
        output rep_active_o, rep_word_o, fill_done_o, busy_o, mem_req_o, mem_addr_o
    );

    modport master (
        output miss_i, miss_addr_i, mem_rvalid_i, mem_rdata_i,
        input  rep_active_o, rep_word_o, fill_done_o, busy_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/fill_line_buffer.sv
// One-block line buffer: register array with a write port and a registered,
// enable-gated read port whose output is the replacement beat.
module fill_line_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 64
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; it drives a top-level output.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/instr_cache_fill_ctrl.sv
// Instruction cache fill responder: fetches one block beat by beat from memory
// into a line buffer, then streams it to the cache set on consecutive cycles.
module instr_cache_fill_ctrl
    import instr_cache_pkg::*;
#(
    parameter int B      = 64,
    parameter int ADDR_W = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    instr_cache_fill_ctrl_if.slave  bus
);
    localparam int BEATS    = B / BEAT_BYTES;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int BLK_BITS = $clog2(B);
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << BLK_BITS) - 64'd1);

    // state        | meaning
    // FILL_IDLE    | waiting for a miss; miss_i is sampled only here
    // FILL_FETCH   | one beat read outstanding; cnt is the beat being fetched
    // FILL_STREAM  | presenting buf[cnt] to the set, one beat per cycle
    // FILL_DONE    | single-cycle fill_done pulse, then back to idle

    fill_state_t       state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] base, base_d;

    logic              busy, busy_d;
    logic              mem_req, mem_req_d;
    logic [ADDR_W-1:0] mem_addr, mem_addr_d;
    logic              rep_active, rep_active_d;
    logic              fill_done, fill_done_d;

    logic              buf_we;
    logic              buf_re;
    logic [CNT_W-1:0]  buf_waddr;
    logic [CNT_W-1:0]  buf_raddr;
    logic [BEAT_W-1:0] buf_rdata;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= FILL_IDLE;
            cnt        <= '0;
            base       <= '0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rep_active <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            base       <= base_d;
            busy       <= busy_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            rep_active <= rep_active_d;
            fill_done  <= fill_done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        base_d  = base;
        case (state)
            FILL_IDLE: begin
                if (bus.miss_i) begin
                    base_d  = bus.miss_addr_i & ~OFFSET_MASK;
                    cnt_d   = '0;
                    state_d = FILL_FETCH;
                end
            end
            FILL_FETCH: begin
                if (bus.mem_rvalid_i) begin
                    if (cnt == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = FILL_STREAM;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            FILL_STREAM: begin
                if (cnt == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = FILL_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            FILL_DONE: begin
                state_d = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe; the buffer read address leads by one cycle.
    always_comb begin
        busy_d       = (state_d != FILL_IDLE);
        mem_req_d    = (state_d == FILL_FETCH);
        rep_active_d = (state_d == FILL_STREAM);
        fill_done_d  = (state_d == FILL_DONE);
        mem_addr_d   = '0;
        if (state_d == FILL_FETCH) begin
            mem_addr_d = base_d + ADDR_W'(cnt_d) * ADDR_W'(BEAT_BYTES);
        end
        buf_we    = (state == FILL_FETCH) && bus.mem_rvalid_i;
        buf_waddr = cnt;
        buf_re    = (state_d == FILL_STREAM);
        buf_raddr = cnt_d;
    end

    fill_line_buffer #(
        .DEPTH (BEATS),
        .AW    (CNT_W),
        .DW    (BEAT_W)
    ) u_line_buffer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .we        (buf_we),
        .waddr     (buf_waddr),
        .wdata     (bus.mem_rdata_i),
        .re        (buf_re),
        .raddr     (buf_raddr),
        .rdata     (buf_rdata)
    );

    assign bus.busy_o       = busy;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.rep_active_o = rep_active;
    assign bus.rep_word_o   = buf_rdata;
    assign bus.fill_done_o  = fill_done;
endmodule

// File: tb/tb_instr_cache_fill_ctrl.sv
// Bench for instr_cache_fill_ctrl: directed fill table, hand-written reset and
// spurious-rvalid sequences, then randomized fills against a block-level model.
module tb_instr_cache_fill_ctrl;
    localparam int B      = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = B / 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_base;
        int          stall_max;
        bit          disturb;
        bit          spur;
        bit          chain;
        logic [31:0] chain_addr;
        logic [31:0] seed;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   cur_disturb = 1'b0;

    instr_cache_fill_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    instr_cache_fill_ctrl #(.B(B), .ADDR_W(ADDR_W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rep_active"}, 64'(bus.rep_active_o), 64'd0);
        chk({tag, "_rep_word"},   bus.rep_word_o,          64'd0);
        chk({tag, "_fill_done"},  64'(bus.fill_done_o),  64'd0);
        chk({tag, "_busy"},       64'(bus.busy_o),       64'd0);
        chk({tag, "_mem_req"},    64'(bus.mem_req_o),    64'd0);
        chk({tag, "_mem_addr"},   64'(bus.mem_addr_o),   64'd0);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cur_disturb) begin
            bus.miss_i      = 1'($urandom_range(0, 1));
            bus.miss_addr_i = $urandom;
        end
    endtask

    // Entered at a falling edge while the DUT is idle; leaves at the falling
    // edge of the idle cycle that follows fill_done.
    task automatic run_fill(input vec_t v);
        logic [63:0] exp_data [BEATS];
        logic [31:0] a;
        int          wait_n;
        bus.miss_i      = 1'b1;
        bus.miss_addr_i = v.addr;
        cyc             = 0;
        cur_disturb     = v.disturb;
        step();
        if (!v.disturb) bus.miss_i = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            a = v.exp_base + 32'(8 * k);
            chk("fetch_req",        64'(bus.mem_req_o),    64'd1);
            chk("fetch_addr",       64'(bus.mem_addr_o),   64'(a));
            chk("fetch_busy",       64'(bus.busy_o),       64'd1);
            chk("fetch_rep_active", 64'(bus.rep_active_o), 64'd0);
            wait_n = 1 + int'($urandom_range(0, v.stall_max));
            for (int s = 0; s < wait_n; s++) begin
                step();
                chk("stall_addr", 64'(bus.mem_addr_o), 64'(a));
                chk("stall_req",  64'(bus.mem_req_o),  64'd1);
            end
            exp_data[k]      = {v.seed, a};
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = exp_data[k];
            step();
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = '0;
        end
        if (v.stall_max == 0) chk("stream_latency", 64'(cyc), 64'(2 * BEATS + 1));
        for (int k = 0; k < BEATS; k++) begin
            chk("stream_active", 64'(bus.rep_active_o), 64'd1);
            chk("stream_word",   bus.rep_word_o,          exp_data[k]);
            chk("stream_req",    64'(bus.mem_req_o),    64'd0);
            chk("stream_done",   64'(bus.fill_done_o),  64'd0);
            chk("stream_busy",   64'(bus.busy_o),       64'd1);
            if (v.spur) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = {$urandom, $urandom};
            end
            step();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        if (v.stall_max == 0) chk("done_latency", 64'(cyc), 64'(3 * BEATS + 1));
        chk("done_pulse",      64'(bus.fill_done_o),  64'd1);
        chk("done_rep_active", 64'(bus.rep_active_o), 64'd0);
        chk("done_busy",       64'(bus.busy_o),       64'd1);
        cur_disturb     = 1'b0;
        bus.miss_i      = v.chain;
        bus.miss_addr_i = v.chain ? v.chain_addr : $urandom;
        step();
        chk("idle_done",       64'(bus.fill_done_o),  64'd0);
        chk("idle_busy",       64'(bus.busy_o),       64'd0);
        chk("idle_req",        64'(bus.mem_req_o),    64'd0);
        chk("idle_rep_active", 64'(bus.rep_active_o), 64'd0);
    endtask

    vec_t vecs [5];
    vec_t rv;

    initial begin
        vecs[0] = '{addr: 32'h0000_1234, exp_base: 32'h0000_1200, stall_max: 0, disturb: 1'b0,
                    spur: 1'b0, chain: 1'b1, chain_addr: 32'h0000_2040, seed: 32'h0};
        vecs[1] = '{addr: 32'h0000_2040, exp_base: 32'h0000_2040, stall_max: 0, disturb: 1'b0,
                    spur: 1'b0, chain: 1'b0, chain_addr: 32'h0, seed: 32'h0};
        vecs[2] = '{addr: 32'hFFFF_FFFF, exp_base: 32'hFFFF_FFC0, stall_max: 5, disturb: 1'b1,
                    spur: 1'b0, chain: 1'b0, chain_addr: 32'h0, seed: 32'hDEAD_BEEF};
        vecs[3] = '{addr: 32'h0000_003F, exp_base: 32'h0000_0000, stall_max: 3, disturb: 1'b0,
                    spur: 1'b1, chain: 1'b0, chain_addr: 32'h0, seed: 32'h1357_9BDF};
        vecs[4] = '{addr: 32'h8000_0041, exp_base: 32'h8000_0040, stall_max: 2, disturb: 1'b1,
                    spur: 1'b1, chain: 1'b0, chain_addr: 32'h0, seed: 32'h0F0F_1234};

        reset_n          = 1'b0;
        bus.miss_i       = 1'b0;
        bus.miss_addr_i  = '0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Reset asserted while a beat request is outstanding.
        bus.miss_i      = 1'b1;
        bus.miss_addr_i = 32'h5555_5555;
        @(negedge clk);
        bus.miss_i = 1'b0;
        chk("rst_fetch_req",  64'(bus.mem_req_o),  64'd1);
        chk("rst_fetch_addr", 64'(bus.mem_addr_o), 64'h5555_5540);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 64'(bus.busy_o),    64'd0);
        chk("post_reset_req",  64'(bus.mem_req_o), 64'd0);

        // Spurious read data while idle must not start anything.
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) begin
            @(negedge clk);
            chk("spur_idle_busy", 64'(bus.busy_o),    64'd0);
            chk("spur_idle_req",  64'(bus.mem_req_o), 64'd0);
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;

        for (int i = 0; i < 5; i++) run_fill(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            rv.addr       = $urandom;
            rv.exp_base   = (rv.addr / 32'(B)) * 32'(B);
            rv.stall_max  = int'($urandom_range(0, 5));
            rv.disturb    = 1'($urandom_range(0, 1));
            rv.spur       = 1'($urandom_range(0, 1));
            rv.chain      = 1'b0;
            rv.chain_addr = '0;
            rv.seed       = $urandom;
            run_fill(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
